// File: rtl/memtrace_sched_pkg.sv
// Shared types and width helpers for the memory-trace lane scheduler.
// The optional statistics counters are enabled with MEMTRACE_SCHED_STATS_EN.
package memtrace_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  localparam int STAT_W = 32;

  // Lane-id width; never narrower than one bit so a single-bit port still exists.
  function automatic int tid_w(input int num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

  function automatic int inflight_w(input int max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

endpackage

// File: rtl/memtrace_rr_arbiter.sv
// Round-robin lane picker: first requesting lane at or after ptr, wrapping.
module memtrace_rr_arbiter
  import memtrace_sched_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic [NUM_LANES-1:0]           req,
  input  logic [tid_w(NUM_LANES)-1:0]    ptr,
  output logic [NUM_LANES-1:0]           grant,
  output logic [tid_w(NUM_LANES)-1:0]    grant_idx,
  output logic                           any_valid
);

  localparam int TW = tid_w(NUM_LANES);

  always_comb begin
    logic found;
    int   j;
    found     = 1'b0;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    any_valid = |req;
    for (int i = 0; i < NUM_LANES; i++) begin
      j = (int'(ptr) + i) % NUM_LANES;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = TW'(j);
      end
    end
  end

endmodule

// File: rtl/memtrace_lane_scheduler.sv
// Serializes a wide trace beat onto one memory-request port, round-robin over lanes
// and bounded by an in-flight credit limit. Define MEMTRACE_SCHED_STATS_EN for counters.
module memtrace_lane_scheduler
  import memtrace_sched_pkg::*;
#(
  parameter int NUM_LANES    = 4,
  parameter int ADDR_W       = 64,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                trace_valid,
  output logic                                trace_ready,
  input  logic [ADDR_W*NUM_LANES-1:0]         trace_address,
  input  logic [NUM_LANES-1:0]                trace_mask,
  input  logic                                trace_finished,
  output logic                                mem_req_valid,
  input  logic                                mem_req_ready,
  output logic [ADDR_W-1:0]                   mem_req_addr,
  output logic [tid_w(NUM_LANES)-1:0]         mem_req_tid,
  input  logic                                mem_resp_valid,
  output logic [inflight_w(MAX_INFLIGHT)-1:0] inflight,
  output logic                                resp_underflow,
  output logic                                done,
`ifdef MEMTRACE_SCHED_STATS_EN
  output logic [STAT_W-1:0]                   stat_issued,
  output logic [STAT_W-1:0]                   stat_credit_stall,
  output logic [STAT_W-1:0]                   stat_mem_stall,
`endif
  output logic [1:0]                          state_dbg
);

  localparam int TW = tid_w(NUM_LANES);
  localparam int IW = inflight_w(MAX_INFLIGHT);

  // Handshake: a request transfers on a cycle where mem_req_valid && mem_req_ready;
  // a beat transfers when trace_valid && trace_ready. Once valid is raised the
  // request (addr/tid) is held stable until it transfers.

  sched_state_e                 state_q, state_d;
  logic [ADDR_W-1:0]            addr_buf_q [NUM_LANES];
  logic [ADDR_W-1:0]            addr_buf_d [NUM_LANES];
  logic [NUM_LANES-1:0]         pending_q, pending_d;
  logic [TW-1:0]                rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]                inflight_q, inflight_d;
  logic                         finish_seen_q, finish_seen_d;
  logic                         done_q, done_d;
  logic                         underflow_q, underflow_d;

  logic [NUM_LANES-1:0]         grant;
  logic [TW-1:0]                grant_idx;
  logic                         any_pending;
  logic                         has_credit;
  logic                         fire;

  memtrace_rr_arbiter #(.NUM_LANES(NUM_LANES)) u_arb (
    .req       (pending_q),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_pending)
  );

  assign has_credit     = (inflight_q < IW'(MAX_INFLIGHT));
  assign mem_req_valid  = (state_q == ST_ISSUE) && any_pending && has_credit;
  assign mem_req_addr   = addr_buf_q[grant_idx];
  assign mem_req_tid    = grant_idx;
  assign fire           = mem_req_valid && mem_req_ready;
  assign trace_ready    = (state_q == ST_IDLE);
  assign inflight       = inflight_q;
  assign resp_underflow = underflow_q;
  assign done           = done_q;
  assign state_dbg      = state_q;

  always_comb begin
    state_d       = state_q;
    addr_buf_d    = addr_buf_q;
    pending_d     = pending_q;
    rr_ptr_d      = rr_ptr_q;
    finish_seen_d = finish_seen_q;
    done_d        = done_q;
    case (state_q)
      ST_IDLE: begin
        if (trace_valid) begin
          for (int g = 0; g < NUM_LANES; g++) begin
            addr_buf_d[g] = trace_address[ADDR_W*g +: ADDR_W];
          end
          pending_d = trace_mask;
          if (trace_finished) finish_seen_d = 1'b1;
          // An empty final beat has nothing to issue, so head straight to drain.
          if (trace_mask != '0)    state_d = ST_ISSUE;
          else if (trace_finished) state_d = ST_DRAIN;
        end else if (trace_finished) begin
          finish_seen_d = 1'b1;
          state_d       = ST_DRAIN;
        end
      end
      ST_ISSUE: begin
        if (fire) begin
          pending_d = pending_q & ~grant;
          rr_ptr_d  = (grant_idx == TW'(NUM_LANES - 1)) ? '0 : grant_idx + TW'(1);
          if ((pending_q & ~grant) == '0) begin
            state_d = finish_seen_q ? ST_DRAIN : ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (inflight_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        done_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    inflight_d  = inflight_q;
    underflow_d = underflow_q;
    if (fire && !mem_resp_valid) begin
      inflight_d = inflight_q + IW'(1);
    end else if (!fire && mem_resp_valid) begin
      if (inflight_q == '0) underflow_d = 1'b1;
      else                  inflight_d  = inflight_q - IW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      rr_ptr_q      <= '0;
      inflight_q    <= '0;
      finish_seen_q <= 1'b0;
      done_q        <= 1'b0;
      underflow_q   <= 1'b0;
      for (int g = 0; g < NUM_LANES; g++) addr_buf_q[g] <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      rr_ptr_q      <= rr_ptr_d;
      inflight_q    <= inflight_d;
      finish_seen_q <= finish_seen_d;
      done_q        <= done_d;
      underflow_q   <= underflow_d;
      for (int g = 0; g < NUM_LANES; g++) addr_buf_q[g] <= addr_buf_d[g];
    end
  end

`ifdef MEMTRACE_SCHED_STATS_EN
  logic [STAT_W-1:0] stat_issued_q, stat_issued_d;
  logic [STAT_W-1:0] stat_credit_q, stat_credit_d;
  logic [STAT_W-1:0] stat_mem_q, stat_mem_d;

  // Counters saturate rather than wrap so long runs never report small numbers.
  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_credit_d = stat_credit_q;
    stat_mem_d    = stat_mem_q;
    if (fire && (stat_issued_q != '1)) stat_issued_d = stat_issued_q + 1'b1;
    if ((pending_q != '0) && (inflight_q == IW'(MAX_INFLIGHT)) && (stat_credit_q != '1))
      stat_credit_d = stat_credit_q + 1'b1;
    if (mem_req_valid && !mem_req_ready && (stat_mem_q != '1)) stat_mem_d = stat_mem_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_issued_q <= '0;
      stat_credit_q <= '0;
      stat_mem_q    <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_credit_q <= stat_credit_d;
      stat_mem_q    <= stat_mem_d;
    end
  end

  assign stat_issued       = stat_issued_q;
  assign stat_credit_stall = stat_credit_q;
  assign stat_mem_stall    = stat_mem_q;
`endif

endmodule

// File: tb/tb_memtrace_lane_scheduler.sv
// Directed bench for memtrace_lane_scheduler with a 4-lane, 2-credit configuration.
module tb_memtrace_lane_scheduler;
  import memtrace_sched_pkg::*;

  localparam int NL = 4;
  localparam int AW = 64;
  localparam int MI = 2;

  logic                  clock;
  logic                  reset;
  logic                  trace_valid;
  logic                  trace_ready;
  logic [AW*NL-1:0]      trace_address;
  logic [NL-1:0]         trace_mask;
  logic                  trace_finished;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [AW-1:0]         mem_req_addr;
  logic [1:0]            mem_req_tid;
  logic                  mem_resp_valid;
  logic [1:0]            inflight;
  logic                  resp_underflow;
  logic                  done;
  logic [1:0]            state_dbg;
`ifdef MEMTRACE_SCHED_STATS_EN
  logic [31:0]           stat_issued, stat_credit_stall, stat_mem_stall;
`endif

  int vectors;
  int miscompares;

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  memtrace_lane_scheduler #(
    .NUM_LANES(NL), .ADDR_W(AW), .MAX_INFLIGHT(MI)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_address  (trace_address),
    .trace_mask     (trace_mask),
    .trace_finished (trace_finished),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_tid    (mem_req_tid),
    .mem_resp_valid (mem_resp_valid),
    .inflight       (inflight),
    .resp_underflow (resp_underflow),
    .done           (done),
`ifdef MEMTRACE_SCHED_STATS_EN
    .stat_issued       (stat_issued),
    .stat_credit_stall (stat_credit_stall),
    .stat_mem_stall    (stat_mem_stall),
`endif
    .state_dbg      (state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    trace_valid    = 1'b0;
    trace_finished = 1'b0;
    trace_mask     = '0;
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic drive_beat(input logic [NL-1:0] mask, input logic fin);
    trace_valid    = 1'b1;
    trace_mask     = mask;
    trace_finished = fin;
    step();
    trace_valid    = 1'b0;
    trace_finished = 1'b0;
  endtask

  task automatic check_req(input string tag, input logic [1:0] tid, input logic [63:0] addr);
    check({tag, ".valid"}, 64'(mem_req_valid), 64'd1);
    check({tag, ".tid"},   64'(mem_req_tid),   64'(tid));
    check({tag, ".addr"},  mem_req_addr,       addr);
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    trace_address  = {64'h400, 64'h300, 64'h200, 64'h100};
    do_reset();

    // Reset values
    check("rst.trace_ready", 64'(trace_ready),    64'd1);
    check("rst.req_valid",   64'(mem_req_valid),  64'd0);
    check("rst.req_addr",    mem_req_addr,        64'd0);
    check("rst.req_tid",     64'(mem_req_tid),    64'd0);
    check("rst.inflight",    64'(inflight),       64'd0);
    check("rst.underflow",   64'(resp_underflow), 64'd0);
    check("rst.done",        64'(done),           64'd0);

    // Full mask, responses returned alongside fires 2..4 to keep a credit free
    drive_beat(4'b1111, 1'b0);
    check("full.t1.ready", 64'(trace_ready), 64'd0);
    check_req("full.t1", 2'd0, 64'h100);
    step();
    check_req("full.t2", 2'd1, 64'h200);
    check("full.t2.inflight", 64'(inflight), 64'd1);
    mem_resp_valid = 1'b1;
    step();
    check_req("full.t3", 2'd2, 64'h300);
    check("full.t3.inflight_same", 64'(inflight), 64'd1);
    step();
    check_req("full.t4", 2'd3, 64'h400);
    step();
    check("full.t5.ready", 64'(trace_ready), 64'd1);
    check("full.t5.valid", 64'(mem_req_valid), 64'd0);
    check("full.t5.inflight", 64'(inflight), 64'd1);
    step();
    mem_resp_valid = 1'b0;
    check("full.drained", 64'(inflight), 64'd0);
    check("full.no_underflow", 64'(resp_underflow), 64'd0);

    // Sparse mask then wrap of the round-robin pointer
    do_reset();
    drive_beat(4'b1010, 1'b0);
    check_req("sparse.a", 2'd1, 64'h200);
    step();
    check_req("sparse.b", 2'd3, 64'h400);
    mem_resp_valid = 1'b1;
    step();
    check("sparse.idle", 64'(trace_ready), 64'd1);
    drive_beat(4'b0011, 1'b0);
    mem_resp_valid = 1'b0;
    check("sparse.inflight0", 64'(inflight), 64'd0);
    check_req("sparse.c", 2'd0, 64'h100);
    step();
    check_req("sparse.d", 2'd1, 64'h200);
    step();
    check("sparse.inflight2", 64'(inflight), 64'd2);

    // Credit limit of two
    do_reset();
    drive_beat(4'b1111, 1'b0);
    check_req("credit.a", 2'd0, 64'h100);
    step();
    check_req("credit.b", 2'd1, 64'h200);
    step();
    check("credit.stall_valid", 64'(mem_req_valid), 64'd0);
    check("credit.stall_inflight", 64'(inflight), 64'd2);
    step();
    check("credit.stall2_valid", 64'(mem_req_valid), 64'd0);
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    check("credit.after_resp_inflight", 64'(inflight), 64'd1);
    check_req("credit.c", 2'd2, 64'h300);
    step();
    check("credit.c_fired_inflight", 64'(inflight), 64'd2);
    check("credit.d_blocked", 64'(mem_req_valid), 64'd0);

    // Response with nothing outstanding
    do_reset();
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    check("uf.flag", 64'(resp_underflow), 64'd1);
    check("uf.inflight", 64'(inflight), 64'd0);
    step();
    check("uf.sticky", 64'(resp_underflow), 64'd1);

    // Finished beat, drain, done
    do_reset();
    drive_beat(4'b0001, 1'b1);
    check_req("fin.req", 2'd0, 64'h100);
    step();
    check("fin.state_drain", 64'(state_dbg), 64'(ST_DRAIN));
    check("fin.inflight1", 64'(inflight), 64'd1);
    check("fin.req_off", 64'(mem_req_valid), 64'd0);
    step();
    step();
    check("fin.not_done", 64'(done), 64'd0);
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    check("fin.inflight0", 64'(inflight), 64'd0);
    check("fin.done_late", 64'(done), 64'd0);
    step();
    check("fin.done", 64'(done), 64'd1);
    step();
    step();
    check("fin.done_held", 64'(done), 64'd1);
    check("fin.ready_low", 64'(trace_ready), 64'd0);

    // Reset in the middle of issue
    do_reset();
    check("fin.done_cleared", 64'(done), 64'd0);
    drive_beat(4'b0111, 1'b0);
    step();
    check("mid.pending_valid", 64'(mem_req_valid), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid.ready", 64'(trace_ready), 64'd1);
    check("mid.valid", 64'(mem_req_valid), 64'd0);
    check("mid.inflight", 64'(inflight), 64'd0);
    check("mid.done", 64'(done), 64'd0);
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0;
    check("mid.stale_resp_underflow", 64'(resp_underflow), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
